// File: rtl/gray_counter.sv
// Up/down counter with a binary core and a registered Gray-coded output.
// Define GRAY_COUNTER_SATURATE_EN to hold at the boundary instead of wrapping.
module gray_counter #(
  parameter int unsigned N = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic         up,
  input  logic         ld,
  input  logic [N-1:0] d,
  output logic [N-1:0] q,
  output logic         tc
);

  localparam logic [N-1:0] one = {{(N-1){1'b0}}, 1'b1};

  if (N < 2 || (N & (N - 1)) != 0) begin : g_bad_width
    $error("gray_counter: N must be a power of 2 and at least 2");
  end

  logic [N-1:0] b;
  logic [N-1:0] b_nxt;

  always_comb begin
    tc = up ? (b == '1) : (b == '0);
  end

  always_comb begin
    b_nxt = b;
    if (ld) begin
      b_nxt = d;
    end else if (en) begin
`ifdef GRAY_COUNTER_SATURATE_EN
      if (!tc) begin
        b_nxt = up ? b + one : b - one;
      end
`else
      b_nxt = up ? b + one : b - one;
`endif
    end
  end

  // q is encoded from the next binary value so it tracks b with no extra cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      b <= '0;
      q <= '0;
    end else begin
      b <= b_nxt;
      q <= b_nxt ^ (b_nxt >> 1);
    end
  end

endmodule

// File: tb/tb_gray_counter.sv
// Randomized self-checking bench for gray_counter against an arithmetic model.
// Honours GRAY_COUNTER_SATURATE_EN the same way as the design.
module tb_gray_counter;

  localparam int unsigned N = 32;
  localparam longint unsigned MODV = 64'h1_0000_0000;
  localparam longint unsigned MAXV = MODV - 1;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         en  = 1'b0;
  logic         up  = 1'b0;
  logic         ld  = 1'b0;
  logic [N-1:0] d   = '0;
  logic [N-1:0] q;
  logic         tc;

  int unsigned checks = 0;
  int unsigned errors = 0;
  longint unsigned mdl = 0;
  bit init = 1'b0;

`ifdef GRAY_COUNTER_SATURATE_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  gray_counter #(.N(N)) dut (
    .clk(clk),
    .rst(rst),
    .en (en),
    .up (up),
    .ld (ld),
    .d  (d),
    .q  (q),
    .tc (tc)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [63:0] gray(input longint unsigned v);
    return 64'(v ^ (v >> 1));
  endfunction

  function automatic logic [63:0] exp_tc(input logic u);
    return u ? 64'(mdl == MAXV) : 64'(mdl == 0);
  endfunction

  // One clock: apply inputs, check tc before the edge, advance model, check q after
  task automatic cyc(input logic r, input logic l, input logic e, input logic u,
                     input logic [N-1:0] dv);
    logic [N-1:0] prevq;
    longint unsigned old;
    bit was_init;
    rst = r; ld = l; en = e; up = u; d = dv;
    #1;
    was_init = init;
    if (init) check("tc", 64'(tc), exp_tc(u));
    prevq = q;
    old = mdl;
    @(posedge clk);
    if (r) begin
      mdl = 0;
      init = 1'b1;
    end else if (l) begin
      mdl = longint'(dv);
    end else if (e) begin
      if (u) begin
        if (!(SAT && mdl == MAXV)) mdl = (mdl + 1) % MODV;
      end else begin
        if (!(SAT && mdl == 0)) mdl = (mdl + MODV - 1) % MODV;
      end
    end
    #1;
    if (init) check("q", 64'(q), gray(mdl));
    if (was_init && !r && !l)
      check("onebit", 64'($countones(q ^ prevq)), (mdl != old) ? 64'd1 : 64'd0);
  endtask

  function automatic logic [N-1:0] pick_d();
    case ($urandom_range(0, 4))
      0: return '0;
      1: return '1;
      2: return N'(1);
      3: return {1'b0, {(N-1){1'b1}}} + N'($urandom_range(0, 3)) - N'(2) ;
      default: return N'($urandom);
    endcase
  endfunction

  initial begin
    logic [31:0] seq [5];
    logic        r, l, e, u;
    seq[0] = 32'h0; seq[1] = 32'h1; seq[2] = 32'h3; seq[3] = 32'h2; seq[4] = 32'h6;

    // reset then four up steps
    cyc(1'b1, 1'b0, 1'b0, 1'b1, '0);
    check("r027_rst", 64'(q), 64'(seq[0]));
    check("r027_tc_up", 64'(tc), 64'd0);
    for (int i = 1; i < 5; i++) begin
      cyc(1'b0, 1'b0, 1'b1, 1'b1, '0);
      check("r027_seq", 64'(q), 64'(seq[i]));
    end

    // load all-ones, then step up across the boundary
    cyc(1'b0, 1'b1, 1'b0, 1'b1, 32'hFFFF_FFFF);
    check("r028_ld", 64'(q), 64'h8000_0000);
    check("r028_tc", 64'(tc), 64'd1);
    cyc(1'b0, 1'b0, 1'b1, 1'b1, '0);
    check("r028_step", 64'(q), SAT ? 64'h8000_0000 : 64'h0);
    check("r028_tc2", 64'(tc), SAT ? 64'd1 : 64'd0);

    // reset with up=0, then step down from zero
    cyc(1'b1, 1'b0, 1'b0, 1'b0, '0);
    check("r029_tc", 64'(tc), 64'd1);
    cyc(1'b0, 1'b0, 1'b1, 1'b0, '0);
    check("r029_step", 64'(q), SAT ? 64'h0 : 64'h8000_0000);

    // load wins over enable
    cyc(1'b0, 1'b1, 1'b1, 1'b1, 32'h0000_0005);
    check("r030_ld", 64'(q), 64'h7);
    cyc(1'b0, 1'b0, 1'b1, 1'b1, '0);
    check("r030_step", 64'(q), 64'h5);

    // hold when en=0
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 32'hDEAD_BEEF);
    check("hold", 64'(q), 64'h5);

    // reset overrides load and enable
    cyc(1'b1, 1'b1, 1'b1, 1'b1, 32'h1234_5678);
    check("r032_rst", 64'(q), 64'h0);

    // long run: en=1, random direction, sparse loads
    for (int i = 0; i < 10000; i++) begin
      r = ($urandom_range(0, 999) == 0);
      l = ($urandom_range(0, 31) == 0);
      u = 1'($urandom);
      cyc(r, l, 1'b1, u, pick_d());
    end

    // short run with random enable for hold coverage
    for (int i = 0; i < 1000; i++) begin
      l = ($urandom_range(0, 31) == 0);
      e = 1'($urandom);
      u = 1'($urandom);
      cyc(1'b0, l, e, u, pick_d());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/gray_counter.md
GRAY_COUNTER -- requirements
Module: gray_counter

Interface
REQ-001 Parameter: N, 32, counter width in bits; SHALL be a power of 2, at least 2.
REQ-002 Port: clk  input  1  single clock, all state updates on rising edge.
REQ-003 Port: rst  input  1  reset, synchronous, active-high.
REQ-004 Port: en  input  1  count enable; one step per cycle while high.
REQ-005 Port: up  input  1  direction; 1 = increment, 0 = decrement, sampled with en.
REQ-006 Port: ld  input  1  parallel load strobe.
REQ-007 Port: d  input  N  load value, binary-encoded.
REQ-008 Port: q  output  N  current count, Gray-encoded, registered; feeds the downstream Gray-to-binary stage.
REQ-009 Port: tc  output  1  terminal count; high when the next enabled step in the current direction wraps or saturates.

Function
REQ-010 Internal state SHALL be an N-bit binary count b; q SHALL be a register equal to b ^ (b >> 1) at all times after the first edge.
REQ-011 Priority per rising edge SHALL be rst > ld > en; lower-priority inputs are ignored that cycle.
REQ-012 ld=1: b <= d, q <= d ^ (d >> 1); en and up ignored.
REQ-013 ld=0, en=1, up=1: b <= b + 1 modulo 2^N; q updates to its Gray code on the same edge.
REQ-014 ld=0, en=1, up=0: b <= b - 1 modulo 2^N.
REQ-015 ld=0, en=0: b and q SHALL hold.
REQ-016 Latency: q SHALL reflect a load or step exactly one cycle after the edge sampling ld/en; no combinational path from d, en or up to q.
REQ-017 Consecutive q values produced by a single step SHALL differ in exactly one bit, including across the wrap from all-ones binary to zero and back.
REQ-018 tc SHALL be combinational from state and up: tc = 1 when (up=1 and b = 2^N-1) or (up=0 and b = 0); independent of en.
REQ-019 Wrap-around: up from b = 2^N-1 gives b = 0 (q = 0); down from b = 0 gives b = 2^N-1 (q = 1 followed by N-1 zeros).
REQ-020 Changing up while en=1 SHALL take effect on the same edge at which it is sampled; no dead cycle.

Reset
REQ-021 rst=1 at a rising edge: b <= 0, q <= 0; tc then equals 1 if up=0, else 0.
REQ-022 rst asserted mid-count or concurrently with ld/en SHALL override both; the count resumes from 0 on the first edge with rst=0.
REQ-023 Before the first reset edge, q and tc are undefined; the bench SHALL NOT check them.

Configuration
REQ-024 Macro GRAY_COUNTER_SATURATE_EN selects the boundary mode.
REQ-025 Without GRAY_COUNTER_SATURATE_EN: wrap-around per REQ-019.
REQ-026 With GRAY_COUNTER_SATURATE_EN: an enabled step with tc=1 SHALL leave b and q unchanged (hold at 2^N-1 going up, at 0 going down); load and reset are unaffected; tc definition unchanged.

Verification
REQ-027 rst for 1 cycle, then en=1, up=1 for 4 cycles -> q = 0x0, 0x1, 0x3, 0x2, 0x6.
REQ-028 ld=1, d=0xFFFFFFFF, then en=1, up=1 -> q = 0x80000000 with tc=1, next cycle q = 0x00000000 and tc=0 (wrap build); q = 0x80000000 held (saturate build).
REQ-029 After reset, en=1, up=0 -> tc=1 before the edge, then q = 0x80000000 (wrap build) or q = 0x0 held (saturate build).
REQ-030 ld=1, d=0x00000005 with en=1, up=1 in the same cycle -> q = 0x00000007 (load wins), next enabled up step q = 0x00000005.
REQ-031 Run en=1 with random up and sparse ld for 10000 cycles -> q equals the Gray code of the reference binary model every cycle, and every non-load step changes exactly one bit of q.
REQ-032 rst=1 asserted together with ld=1, d=0x12345678, en=1 -> q = 0x0 next cycle.
